inst_fetch_unit: RTL and testbench
==================================

Name: inst_fetch_unit

Overview:
- Instruction fetch/issue stage that produces the Opcode/Funct stream consumed by the main control decoder.
- Holds the PC and fetches one 32-bit word at a time from instruction memory over a req/ack handshake.
- Presents the word to the decode stage over a valid/ready handshake.
- Applies control-flow redirects (J, JAL, JR, taken BEQ) resolved downstream.

Parameters:
- PC_WIDTH, 32, width of PC and memory address.
- RESET_PC, 32'h0000_0000, PC loaded on reset; must be word-aligned.

Ports:
- clk  in  1  single clock; all state updates on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- imem_req  out  1  fetch request to instruction memory.
- imem_addr  out  PC_WIDTH  fetch address; stable while imem_req=1 and imem_ack=0.
- imem_ack  in  1  memory accepted the request; imem_rdata valid in the same cycle.
- imem_rdata  in  32  fetched instruction word.
- inst_valid  out  1  instr/opcode/funct/pc_out/pc_plus4 valid to decode.
- inst_ready  in  1  decode accepts the word this cycle.
- instr  out  32  registered instruction word.
- opcode  out  6  instr[31:26].
- funct  out  6  instr[5:0].
- pc_out  out  PC_WIDTH  address of instr.
- pc_plus4  out  PC_WIDTH  pc_out+4 (JAL link value).
- redir_valid  in  1  one-cycle redirect strobe from branch/jump resolution.
- redir_pc  in  PC_WIDTH  redirect target.
- align_err  out  1  one-cycle pulse when redir_pc[1:0]!=0.

Behaviour:
- Reset (async, rst_n=0):
  - pc=RESET_PC, state=IDLE.
  - imem_req=0, inst_valid=0, instr=0, pc_out=RESET_PC, pc_plus4=RESET_PC+4, align_err=0.
  - Reset mid-fetch drops imem_req immediately; the memory tolerates an abandoned request.
- FSM states: IDLE, FETCH, DISCARD, VALID.
- IDLE:
  - Entered only from reset; occupies the first clock after rst_n rises.
  - Next state FETCH.
- FETCH:
  - imem_req=1, imem_addr=pc.
  - On imem_ack: instr<=imem_rdata, pc_out<=pc, pc_plus4<=pc+4, go VALID.
  - Latency: ack in cycle N gives inst_valid=1 in cycle N+1.
  - Minimum fetch-to-fetch spacing is 2 cycles; one request outstanding at most.
- VALID:
  - inst_valid=1, imem_req=0; outputs hold until the handshake completes.
  - On inst_valid&inst_ready: pc<=pc+4, go FETCH.
- Redirect (redir_valid=1):
  - pc<=redir_pc with bits[1:0] forced to 0; align_err pulses the next cycle if the original bits[1:0]!=0.
  - In VALID: the held word is dropped, inst_valid=0 next cycle, go FETCH. This applies even if inst_ready=1 that cycle: the word counts as consumed and pc takes redir_pc, not pc+4.
  - In FETCH without ack: the request is not aborted and imem_addr is not changed. Go DISCARD.
  - In FETCH with ack the same cycle: the returned data is discarded, go FETCH at the new pc.
  - In DISCARD: pc is updated again (last redirect wins).
  - In IDLE: pc is updated; the first fetch uses redir_pc.
- DISCARD:
  - imem_req=1 at the old address.
  - On imem_ack: drop imem_rdata, no inst_valid, go FETCH at the redirected pc.
- Arithmetic:
  - pc+4 is modulo 2^PC_WIDTH, so 32'hFFFF_FFFC wraps to 0.
  - pc_plus4 uses the same wrap rule.
- opcode and funct are combinational slices of registered instr. They are meaningful only while inst_valid=1, and hold their last value otherwise.
- inst_ready while inst_valid=0 has no effect.

Test Plan:
- Reset release, memory acks every request in 1 cycle, inst_ready=1 -> addresses 0x0, 0x4, 0x8; inst_valid high every 2nd cycle; opcode/funct match rdata fields, e.g. 0x012A4020 gives opcode 0, funct 0x20.
- Backpressure: inst_ready=0 for 5 cycles with word 0x8D090004 held -> instr, pc_out, inst_valid stable, imem_req=0; ready=1 -> next fetch at pc+4.
- Redirect during outstanding request: req to 0x10 unacked, redir_pc=0x40, ack 3 cycles later -> imem_addr stays 0x10 until ack, data dropped, next req at 0x40, first inst_valid shows pc_out=0x40, pc_plus4=0x44.
- Redirect and handshake in the same cycle in VALID, redir_pc=0x100 -> next imem_addr=0x100, not pc+4; no duplicate inst_valid.
- Misaligned redirect 0x103 -> fetch at 0x100, align_err one-cycle pulse. Separately, pc=0xFFFFFFFC accepted -> next fetch at 0x0, pc_plus4=0x0.
- Async reset asserted mid-FETCH -> imem_req=0 immediately; after release, fetch restarts at RESET_PC.

Source files
------------

// File: rtl/inst_fetch_unit_if.sv
// rtl/inst_fetch_unit_if.sv - fetch unit bus bundle: imem req/ack, decode valid/ready, redirect
// master is the fetch unit; slave is the memory/decode/redirect side.
interface inst_fetch_unit_if #(
    parameter int PC_WIDTH = 32
);
    logic                imem_req;
    logic [PC_WIDTH-1:0] imem_addr;
    logic                imem_ack;
    logic [31:0]         imem_rdata;

    logic                inst_valid;
    logic                inst_ready;
    logic [31:0]         instr;
    logic [5:0]          opcode;
    logic [5:0]          funct;
    logic [PC_WIDTH-1:0] pc_out;
    logic [PC_WIDTH-1:0] pc_plus4;

    logic                redir_valid;
    logic [PC_WIDTH-1:0] redir_pc;
    logic                align_err;

    modport master (
        output imem_req, imem_addr,
        input  imem_ack, imem_rdata,
        output inst_valid, instr, opcode, funct, pc_out, pc_plus4,
        input  inst_ready,
        input  redir_valid, redir_pc,
        output align_err
    );

    modport slave (
        input  imem_req, imem_addr,
        output imem_ack, imem_rdata,
        input  inst_valid, instr, opcode, funct, pc_out, pc_plus4,
        output inst_ready,
        output redir_valid, redir_pc,
        input  align_err
    );
endinterface

// File: rtl/inst_fetch_unit.sv
// rtl/inst_fetch_unit.sv - PC holder, single-outstanding instruction fetch and decode issue
// Redirects resolved downstream retarget the PC; an in-flight request is completed then dropped.
module inst_fetch_unit #(
    parameter int                  PC_WIDTH = 32,
    parameter logic [PC_WIDTH-1:0] RESET_PC = '0
) (
    input  logic              clk,
    input  logic              rst_n,
    inst_fetch_unit_if.master bus
);
    typedef enum logic [1:0] {IDLE, FETCH, DISCARD, VALID} state_t;

    state_t              state_q;
    logic [PC_WIDTH-1:0] pc_q;
    logic [PC_WIDTH-1:0] addr_q;
    logic [PC_WIDTH-1:0] pc_out_q;
    logic [PC_WIDTH-1:0] pc_plus4_q;
    logic [31:0]         instr_q;
    logic                req_q;
    logic                valid_q;
    logic                align_err_q;

    logic                redir;
    logic [PC_WIDTH-1:0] redir_pc_d;
    logic [PC_WIDTH-1:0] pc_inc_d;

    assign redir      = bus.redir_valid;
    assign redir_pc_d = {bus.redir_pc[PC_WIDTH-1:2], 2'b00};
    assign pc_inc_d   = pc_q + PC_WIDTH'(4);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            pc_q        <= RESET_PC;
            addr_q      <= RESET_PC;
            pc_out_q    <= RESET_PC;
            pc_plus4_q  <= RESET_PC + PC_WIDTH'(4);
            instr_q     <= '0;
            req_q       <= 1'b0;
            valid_q     <= 1'b0;
            align_err_q <= 1'b0;
        end else begin
            align_err_q <= redir && (bus.redir_pc[1:0] != 2'b00);
            if (redir) begin
                pc_q <= redir_pc_d;
            end
            case (state_q)
                IDLE: begin
                    state_q <= FETCH;
                    req_q   <= 1'b1;
                    addr_q  <= redir ? redir_pc_d : pc_q;
                end
                FETCH: begin
                    if (bus.imem_ack) begin
                        if (redir) begin
                            // Returned word is stale; reissue at the new target right away.
                            addr_q <= redir_pc_d;
                        end else begin
                            instr_q    <= bus.imem_rdata;
                            pc_out_q   <= pc_q;
                            pc_plus4_q <= pc_inc_d;
                            valid_q    <= 1'b1;
                            req_q      <= 1'b0;
                            state_q    <= VALID;
                        end
                    end else if (redir) begin
                        state_q <= DISCARD;
                    end
                end
                DISCARD: begin
                    if (bus.imem_ack) begin
                        state_q <= FETCH;
                        addr_q  <= redir ? redir_pc_d : pc_q;
                    end
                end
                VALID: begin
                    if (redir) begin
                        valid_q <= 1'b0;
                        req_q   <= 1'b1;
                        addr_q  <= redir_pc_d;
                        state_q <= FETCH;
                    end else if (bus.inst_ready) begin
                        pc_q    <= pc_inc_d;
                        addr_q  <= pc_inc_d;
                        valid_q <= 1'b0;
                        req_q   <= 1'b1;
                        state_q <= FETCH;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.imem_req   = req_q;
    assign bus.imem_addr  = addr_q;
    assign bus.inst_valid = valid_q;
    assign bus.instr      = instr_q;
    assign bus.opcode     = instr_q[31:26];
    assign bus.funct      = instr_q[5:0];
    assign bus.pc_out     = pc_out_q;
    assign bus.pc_plus4   = pc_plus4_q;
    assign bus.align_err  = align_err_q;
endmodule

// File: tb/tb_inst_fetch_unit.sv
// tb/tb_inst_fetch_unit.sv - bench for inst_fetch_unit: vector table, corner sequences, random run
module tb_inst_fetch_unit;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_pass = 0;
    int   n_total = 0;

    inst_fetch_unit_if #(.PC_WIDTH(32)) bus ();

    inst_fetch_unit #(.PC_WIDTH(32), .RESET_PC(32'h0)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        ack;
        logic [31:0] rdata;
        logic        ready;
        logic        rv;
        logic [31:0] rpc;
        logic        e_req;
        logic [31:0] e_addr;
        logic        e_valid;
        logic [31:0] e_instr;
        logic [31:0] e_pc;
        logic        e_align;
    } vec_t;

    vec_t vecs [17];

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) $display("FAIL %s: got %h expected %h", name, got, exp);
        else n_pass++;
    endtask

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
    endfunction

    task automatic drive(input logic ack, input logic [31:0] rdata, input logic ready,
                         input logic rv, input logic [31:0] rpc);
        bus.imem_ack    = ack;
        bus.imem_rdata  = rdata;
        bus.inst_ready  = ready;
        bus.redir_valid = rv;
        bus.redir_pc    = rpc;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset();
        bus.imem_ack    = 1'b0;
        bus.imem_rdata  = '0;
        bus.inst_ready  = 1'b0;
        bus.redir_valid = 1'b0;
        bus.redir_pc    = '0;
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic chk_word(input string tag, input logic [31:0] e_instr, input logic [31:0] e_pc);
        chk({tag, " valid"}, 32'(bus.inst_valid), 32'd1);
        chk({tag, " instr"}, bus.instr, e_instr);
        chk({tag, " pc_out"}, bus.pc_out, e_pc);
        chk({tag, " pc_plus4"}, bus.pc_plus4, e_pc + 32'd4);
        chk({tag, " opcode"}, 32'(bus.opcode), 32'(e_instr[31:26]));
        chk({tag, " funct"}, 32'(bus.funct), 32'(e_instr[5:0]));
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0]  = '{1'b0, 32'h0, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0, 32'h0, 1'b0};
        vecs[1]  = '{1'b1, 32'h012A4020, 1'b1, 1'b0, 32'h0, 1'b1, 32'h0, 1'b0, 32'h0, 32'h0, 1'b0};
        vecs[2]  = '{1'b0, 32'h0, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1, 32'h012A4020, 32'h0, 1'b0};
        vecs[3]  = '{1'b1, 32'h8D090004, 1'b0, 1'b0, 32'h0, 1'b1, 32'h4, 1'b0, 32'h0, 32'h0, 1'b0};
        for (int i = 4; i <= 8; i++)
            vecs[i] = '{1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1, 32'h8D090004, 32'h4, 1'b0};
        vecs[9]  = '{1'b0, 32'h0, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1, 32'h8D090004, 32'h4, 1'b0};
        vecs[10] = '{1'b1, 32'h3C010001, 1'b1, 1'b0, 32'h0, 1'b1, 32'h8, 1'b0, 32'h0, 32'h0, 1'b0};
        vecs[11] = '{1'b0, 32'h0, 1'b1, 1'b1, 32'h100, 1'b0, 32'h0, 1'b1, 32'h3C010001, 32'h8, 1'b0};
        vecs[12] = '{1'b1, 32'hAC220000, 1'b1, 1'b0, 32'h0, 1'b1, 32'h100, 1'b0, 32'h0, 32'h0, 1'b0};
        vecs[13] = '{1'b0, 32'h0, 1'b0, 1'b1, 32'h103, 1'b0, 32'h0, 1'b1, 32'hAC220000, 32'h100, 1'b0};
        vecs[14] = '{1'b1, 32'h10000005, 1'b1, 1'b0, 32'h0, 1'b1, 32'h100, 1'b0, 32'h0, 32'h0, 1'b1};
        vecs[15] = '{1'b0, 32'h0, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1, 32'h10000005, 32'h100, 1'b0};
        vecs[16] = '{1'b0, 32'h0, 1'b1, 1'b0, 32'h0, 1'b1, 32'h104, 1'b0, 32'h0, 32'h0, 1'b0};

        // Reset state, sampled while rst_n is low
        bus.imem_ack = 1'b0; bus.imem_rdata = '0; bus.inst_ready = 1'b0;
        bus.redir_valid = 1'b0; bus.redir_pc = '0;
        repeat (2) @(negedge clk);
        chk("rst imem_req", 32'(bus.imem_req), 32'd0);
        chk("rst inst_valid", 32'(bus.inst_valid), 32'd0);
        chk("rst instr", bus.instr, 32'h0);
        chk("rst pc_out", bus.pc_out, 32'h0);
        chk("rst pc_plus4", bus.pc_plus4, 32'h4);
        chk("rst align_err", 32'(bus.align_err), 32'd0);

        // Vector table: fetch stream, backpressure, redirect+handshake, misaligned redirect
        do_reset();
        for (int i = 0; i < 17; i++) begin
            string tag;
            tag = $sformatf("vec%0d", i);
            chk({tag, " req"}, 32'(bus.imem_req), 32'(vecs[i].e_req));
            chk({tag, " valid"}, 32'(bus.inst_valid), 32'(vecs[i].e_valid));
            chk({tag, " align"}, 32'(bus.align_err), 32'(vecs[i].e_align));
            if (vecs[i].e_req) chk({tag, " addr"}, bus.imem_addr, vecs[i].e_addr);
            if (vecs[i].e_valid) chk_word(tag, vecs[i].e_instr, vecs[i].e_pc);
            drive(vecs[i].ack, vecs[i].rdata, vecs[i].ready, vecs[i].rv, vecs[i].rpc);
        end

        // Redirect in IDLE to 0x10, then redirect to 0x40 with 0x10 outstanding
        do_reset();
        drive(1'b0, 32'h0, 1'b0, 1'b1, 32'h10);
        chk("disc c1 req", 32'(bus.imem_req), 32'd1);
        chk("disc c1 addr", bus.imem_addr, 32'h10);
        drive(1'b0, 32'h0, 1'b1, 1'b1, 32'h40);
        for (int i = 0; i < 2; i++) begin
            chk("disc hold req", 32'(bus.imem_req), 32'd1);
            chk("disc hold addr", bus.imem_addr, 32'h10);
            chk("disc hold valid", 32'(bus.inst_valid), 32'd0);
            drive(1'b0, 32'h0, 1'b1, 1'b0, 32'h0);
        end
        chk("disc ack addr", bus.imem_addr, 32'h10);
        drive(1'b1, 32'hDEADBEEF, 1'b1, 1'b0, 32'h0);
        chk("disc refetch req", 32'(bus.imem_req), 32'd1);
        chk("disc refetch addr", bus.imem_addr, 32'h40);
        chk("disc dropped valid", 32'(bus.inst_valid), 32'd0);
        drive(1'b1, 32'h20000040, 1'b0, 1'b0, 32'h0);
        chk_word("disc", 32'h20000040, 32'h40);

        // PC wrap at the top of the address space
        do_reset();
        drive(1'b0, 32'h0, 1'b0, 1'b1, 32'hFFFF_FFFC);
        chk("wrap addr", bus.imem_addr, 32'hFFFF_FFFC);
        drive(1'b1, 32'h0800_0000, 1'b0, 1'b0, 32'h0);
        chk("wrap pc_out", bus.pc_out, 32'hFFFF_FFFC);
        chk("wrap pc_plus4", bus.pc_plus4, 32'h0);
        drive(1'b0, 32'h0, 1'b1, 1'b0, 32'h0);
        chk("wrap next req", 32'(bus.imem_req), 32'd1);
        chk("wrap next addr", bus.imem_addr, 32'h0);

        // Async reset in the middle of a fetch
        do_reset();
        drive(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
        drive(1'b0, 32'h0, 1'b0, 1'b1, 32'h80);
        chk("areset pre req", 32'(bus.imem_req), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("areset req drop", 32'(bus.imem_req), 32'd0);
        chk("areset valid", 32'(bus.inst_valid), 32'd0);
        bus.redir_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        chk("areset idle req", 32'(bus.imem_req), 32'd0);
        drive(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
        chk("areset restart req", 32'(bus.imem_req), 32'd1);
        chk("areset restart addr", bus.imem_addr, 32'h0);

        // Random traffic against a program-order model
        begin
            logic [31:0] exp_pc;
            logic        exp_align;
            logic        prev_pending;
            logic [31:0] prev_addr;
            int          wait_cnt;
            int          stall;
            logic        ack, ready, rv, hs;
            logic [31:0] rdata, rpc;
            do_reset();
            exp_pc = 32'h0; exp_align = 1'b0; prev_pending = 1'b0; prev_addr = '0;
            wait_cnt = -1; stall = 0;
            for (int cyc = 0; cyc < 3000; cyc++) begin
                chk("rnd align_err", 32'(bus.align_err), 32'(exp_align));
                if (prev_pending) begin
                    chk("rnd req held", 32'(bus.imem_req), 32'd1);
                    chk("rnd addr stable", bus.imem_addr, prev_addr);
                end
                if (bus.inst_valid) begin
                    chk_word("rnd", mem_word(exp_pc), exp_pc);
                    stall = 0;
                end else begin
                    stall++;
                    if (stall > 60) begin
                        chk("rnd progress stall", 32'(stall), 32'd60);
                        break;
                    end
                end
                ack = 1'b0; rdata = $urandom;
                if (bus.imem_req) begin
                    if (wait_cnt < 0) wait_cnt = $urandom_range(0, 3);
                    if (wait_cnt == 0) begin
                        ack = 1'b1;
                        rdata = mem_word(bus.imem_addr);
                        wait_cnt = -1;
                    end else begin
                        wait_cnt--;
                    end
                end
                ready = ($urandom_range(0, 3) != 0);
                rv    = ($urandom_range(0, 9) == 0);
                rpc   = ($urandom_range(0, 7) == 0) ? (32'hFFFF_FFF8 | 32'($urandom_range(0, 7)))
                                                    : 32'($urandom_range(0, 1023));
                hs = bus.inst_valid && ready;
                prev_pending = bus.imem_req && !ack;
                prev_addr    = bus.imem_addr;
                drive(ack, rdata, ready, rv, rpc);
                if (rv) exp_pc = {rpc[31:2], 2'b00};
                else if (hs) exp_pc = exp_pc + 32'd4;
                exp_align = rv && (rpc[1:0] != 2'b00);
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
